// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//
// Shared types and elaboration helpers for the pipelined shift/rotate unit.
//   shift_op_e       : operation encoding carried on in_op (3 bits, 101..111
//                      are reserved and produce a zero result)
//   fill_e           : what enters at the MSB end while shifting right
//   levels_per_stage : shift levels handled by each register stage
//   stage_levels     : levels actually owned by stage k (can be 0 for the
//                      trailing stages of a deep pipe)
//   is_left          : ops executed as reverse / shift right / reverse
//   is_known_op      : false for reserved encodings
//   fill_of          : fill mode implied by an op
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } shift_op_e;

  typedef enum logic [1:0] {
    FILL_ZERO,
    FILL_SIGN,
    FILL_ROT
  } fill_e;

  // ceil(log2(xlen) / pipe); guarded so a bad pipe value reaches the
  // parameter check instead of dividing by zero.
  function automatic int levels_per_stage(input int xlen, input int pipe);
    if (pipe < 1) return 1;
    return ($clog2(xlen) + pipe - 1) / pipe;
  endfunction

  // Number of levels stage k applies: [k*C, min((k+1)*C, L)).
  function automatic int stage_levels(input int xlen, input int pipe, input int k);
    int c;
    int lo;
    int hi;
    c  = levels_per_stage(xlen, pipe);
    lo = k * c;
    hi = (k + 1) * c;
    if (hi > $clog2(xlen)) hi = $clog2(xlen);
    return (hi > lo) ? (hi - lo) : 0;
  endfunction

  function automatic logic is_left(input logic [OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_ROL);
  endfunction

  function automatic logic is_known_op(input logic [OP_W-1:0] op);
    return op <= OP_ROR;
  endfunction

  function automatic fill_e fill_of(input logic [OP_W-1:0] op);
    case (op)
      OP_SRA:         return FILL_SIGN;
      OP_ROL, OP_ROR: return FILL_ROT;
      default:        return FILL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
//
// One register stage of the shift pipe. Applies right-shift levels
// FIRST_LVL .. FIRST_LVL+NUM_LVL-1 (distances 2**lvl) to in_data, selected by
// the matching in_shamt bits, with the fill implied by in_op. The result and
// its side-band (tag, op, word flag, shamt) are registered when the stage
// advances.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous kill; stage ends empty
//   in_valid        upstream has an entry for this stage
//   in_ready        this stage can take an entry this cycle
//   in_data/tag/op/word/shamt   upstream entry
//   out_valid       this stage holds an entry
//   out_ready       downstream takes the entry this cycle
//   out_data/tag/op/word/shamt  registered entry
// -----------------------------------------------------------------------------
module shift_stage
  import shift_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 5,
  parameter int FIRST_LVL = 0,
  parameter int NUM_LVL   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_data,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [OP_W-1:0]            in_op,
  input  logic                       in_word,
  input  logic [$clog2(XLEN)-1:0]    in_shamt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_data,
  output logic [TAG_W-1:0]           out_tag,
  output logic [OP_W-1:0]            out_op,
  output logic                       out_word,
  output logic [$clog2(XLEN)-1:0]    out_shamt
);

  logic [XLEN-1:0] shifted;
  logic            load;

  if (NUM_LVL == 0) begin : g_pass
    // Deep pipes leave trailing stages with no levels; they only retime.
    assign shifted = in_data;
  end else begin : g_shift
    fill_e           fill;
    logic [XLEN-1:0] lvl_data [NUM_LVL+1];

    assign fill        = fill_of(in_op);
    assign lvl_data[0] = in_data;

    for (genvar i = 0; i < NUM_LVL; i++) begin : g_lvl
      localparam int AMT = 1 << (FIRST_LVL + i);
      logic [AMT-1:0] fill_bits;

      // NOTE: every branch assigns fill_bits (default included), so this
      // stays pure combinational logic and no latch is inferred.
      always_comb begin
        case (fill)
          // Arithmetic right shifts keep the MSB equal to the original sign
          // bit, so the current MSB is the sign of the pre-processed operand.
          FILL_SIGN: fill_bits = {AMT{lvl_data[i][XLEN-1]}};
          FILL_ROT:  fill_bits = lvl_data[i][AMT-1:0];
          default:   fill_bits = '0;
        endcase
      end

      assign lvl_data[i+1] = in_shamt[FIRST_LVL+i]
                           ? {fill_bits, lvl_data[i][XLEN-1:AMT]}
                           : lvl_data[i];
    end

    assign shifted = lvl_data[NUM_LVL];
  end

  // Ready only looks at our own valid bit and downstream ready, so there is no
  // combinational path from in_valid back to in_ready.
  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready && !flush;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbours' pre-edge values, whatever the evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
    end
  end

  // NOTE: the payload registers are reset too, because the last stage drives
  // out_data/out_tag directly and those must read zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_tag   <= '0;
      out_op    <= '0;
      out_word  <= 1'b0;
      out_shamt <= '0;
    end else if (load) begin
      out_data  <= shifted;
      out_tag   <= in_tag;
      out_op    <= in_op;
      out_word  <= in_word;
      out_shamt <= in_shamt;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
//
// Pipelined shift/rotate unit (SLL, SRL, SRA, ROL, ROR) with RV64 word mode,
// PIPE register stages and a valid/ready handshake with flush. One operation
// per cycle, results in order, latency PIPE cycles from acceptance.
//
// Datapath: entry pre-processing (word extension, bit reversal for left ops,
// zeroing of reserved ops) -> PIPE shift_stage instances each owning a slice
// of the log2(XLEN) right-shift levels -> exit post-processing (bit reversal
// for left ops, sign extension of word results).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 kill all in-flight ops at the next edge
//   in_valid/in_ready     input handshake
//   in_op                 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR
//   in_word               *W semantics (XLEN=64 only)
//   in_shamt              shift amount
//   in_data, in_tag       operand and passthrough tag
//   out_valid/out_ready   output handshake
//   out_data, out_tag     result and its tag
// -----------------------------------------------------------------------------
module shift_pipe
  import shift_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PIPE  = 2,
  parameter int TAG_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         in_op,
  input  logic                    in_word,
  input  logic [$clog2(XLEN)-1:0] in_shamt,
  input  logic [XLEN-1:0]         in_data,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int SHAMT_W = $clog2(XLEN);
  localparam int C       = levels_per_stage(XLEN, PIPE);

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("shift_pipe: XLEN must be 32 or 64");
  end
  if (PIPE < 1 || PIPE > SHAMT_W) begin : g_bad_pipe
    $error("shift_pipe: PIPE must be in 1..log2(XLEN)");
  end

  // Stage chain; index 0 is the pre-processed input, index PIPE the last
  // stage's registers.
  logic [XLEN-1:0]    st_data  [PIPE+1];
  logic [TAG_W-1:0]   st_tag   [PIPE+1];
  logic [OP_W-1:0]    st_op    [PIPE+1];
  logic               st_word  [PIPE+1];
  logic [SHAMT_W-1:0] st_shamt [PIPE+1];
  logic               st_valid [PIPE+1];
  logic               st_ready [PIPE+1];

  // ---------------------------------------------------------------------------
  // Entry pre-processing
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]    word_data;
  logic               word_en;
  logic [XLEN-1:0]    sel_data;
  logic [XLEN-1:0]    entry_data;
  logic [SHAMT_W-1:0] entry_shamt;

  if (XLEN == 64) begin : g_word
    // Arrange the low word so a plain 64-bit shift yields the *W result in
    // the low 32 bits; rotates see two copies so wrapped bits are correct.
    always_comb begin
      case (in_op)
        OP_SRL:         word_data = {32'b0, in_data[31:0]};
        OP_SRA:         word_data = {{32{in_data[31]}}, in_data[31:0]};
        OP_ROL, OP_ROR: word_data = {2{in_data[31:0]}};
        default:        word_data = in_data;
      endcase
    end
    assign word_en = in_word;
  end else begin : g_noword
    assign word_data = in_data;
    assign word_en   = 1'b0;
  end

  always_comb begin
    sel_data   = word_en ? word_data : in_data;
    entry_data = sel_data;
    if (is_left(in_op)) begin
      for (int i = 0; i < XLEN; i++) entry_data[i] = sel_data[XLEN-1-i];
    end
    // Reserved ops travel as a zero operand with zero fill: result is 0.
    if (!is_known_op(in_op)) entry_data = '0;
    entry_shamt = word_en ? (in_shamt & SHAMT_W'(31)) : in_shamt;
  end

  assign st_data[0]  = entry_data;
  assign st_tag[0]   = in_tag;
  assign st_op[0]    = in_op;
  assign st_word[0]  = word_en;
  assign st_shamt[0] = entry_shamt;
  assign st_valid[0] = in_valid;

  // ---------------------------------------------------------------------------
  // Register stages
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < PIPE; k++) begin : g_stage
    shift_stage #(
      .XLEN      (XLEN),
      .TAG_W     (TAG_W),
      .FIRST_LVL (k * C),
      .NUM_LVL   (stage_levels(XLEN, PIPE, k))
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (st_valid[k]),
      .in_ready  (st_ready[k]),
      .in_data   (st_data[k]),
      .in_tag    (st_tag[k]),
      .in_op     (st_op[k]),
      .in_word   (st_word[k]),
      .in_shamt  (st_shamt[k]),
      .out_valid (st_valid[k+1]),
      .out_ready (st_ready[k+1]),
      .out_data  (st_data[k+1]),
      .out_tag   (st_tag[k+1]),
      .out_op    (st_op[k+1]),
      .out_word  (st_word[k+1]),
      .out_shamt (st_shamt[k+1])
    );
  end

  assign st_ready[PIPE] = out_ready;
  assign in_ready       = !flush && st_ready[0];

  // ---------------------------------------------------------------------------
  // Exit post-processing (combinational on the last stage's registers)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] last_data;
  logic [XLEN-1:0] unrev_data;

  always_comb begin
    last_data  = st_data[PIPE];
    unrev_data = last_data;
    if (is_left(st_op[PIPE])) begin
      for (int i = 0; i < XLEN; i++) unrev_data[i] = last_data[XLEN-1-i];
    end
  end

  if (XLEN == 64) begin : g_sext
    assign out_data = st_word[PIPE] ? {{32{unrev_data[31]}}, unrev_data[31:0]}
                                    : unrev_data;
  end else begin : g_nosext
    assign out_data = unrev_data;
  end

  assign out_valid = st_valid[PIPE];
  assign out_tag   = st_tag[PIPE];

  // The last stage's shamt has no consumer, and word mode is inert at XLEN=32.
  logic unused_bits;
  assign unused_bits = ^{st_shamt[PIPE], st_word[PIPE], in_word};

endmodule

// File: tb/tb_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_pipe
//
// Self-checking bench for shift_pipe at XLEN=64, PIPE=2. Inputs change on the
// falling edge; handshakes are evaluated 1 time unit later and take effect at
// the following rising edge. Expected results come from a behavioural model
// built on the SV shift operators, held in an in-order queue.
// -----------------------------------------------------------------------------
module tb_shift_pipe;

  localparam int XLEN  = 64;
  localparam int PIPE  = 2;
  localparam int TAG_W = 5;
  localparam int SW    = 6;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             flush     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op     = '0;
  logic             in_word   = 1'b0;
  logic [SW-1:0]    in_shamt  = '0;
  logic [XLEN-1:0]  in_data   = '0;
  logic [TAG_W-1:0] in_tag    = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  shift_pipe #(.XLEN(XLEN), .PIPE(PIPE), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_word   (in_word),
    .in_shamt  (in_shamt),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  bit   sb_on    = 1'b0;
  bit   last_fire_in;
  bit   last_fire_out;

  // Reference: straight from the operation definitions.
  function automatic logic [63:0] model(input logic [2:0] op, input logic word,
                                        input logic [5:0] sh, input logic [63:0] d);
    logic [31:0] w;
    logic [31:0] r32;
    logic [63:0] r;
    int s;
    if (word) begin
      s = int'(sh[4:0]);
      w = d[31:0];
      case (op)
        3'd0:    r32 = w << s;
        3'd1:    r32 = w >> s;
        3'd2:    r32 = $signed(w) >>> s;
        3'd3:    r32 = (s == 0) ? w : ((w << s) | (w >> (32 - s)));
        3'd4:    r32 = (s == 0) ? w : ((w >> s) | (w << (32 - s)));
        default: return 64'd0;
      endcase
      return {{32{r32[31]}}, r32};
    end
    s = int'(sh);
    case (op)
      3'd0:    r = d << s;
      3'd1:    r = d >> s;
      3'd2:    r = $signed(d) >>> s;
      3'd3:    r = (s == 0) ? d : ((d << s) | (d >> (64 - s)));
      3'd4:    r = (s == 0) ? d : ((d >> s) | (d << (64 - s)));
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // One clock: evaluate handshakes with inputs settled, update the scoreboard,
  // then move to the next falling edge.
  task automatic cycle();
    exp_t e;
    #1;
    last_fire_in  = in_valid && in_ready;
    last_fire_out = out_valid && out_ready;
    if (sb_on) begin
      if (last_fire_out) begin
        n_out++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: got data=%h tag=%h, required no output", out_data, out_tag);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_tag !== e.tag) begin
            n_fail++;
            $display("FAIL sb_result: got data=%h tag=%h, required data=%h tag=%h",
                     out_data, out_tag, e.data, e.tag);
          end
        end
      end
      if (last_fire_in) begin
        e.data = model(in_op, in_word, in_shamt, in_data);
        e.tag  = in_tag;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    if (sb_on && flush) exp_q.delete();
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() > 0; i++) cycle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  // Single op into an empty pipe with out_ready high; checks acceptance,
  // exact latency, result and tag.
  task automatic run_one(input string name, input logic [2:0] op, input logic word,
                         input logic [5:0] sh, input logic [63:0] d,
                         input logic [4:0] tag, input logic [63:0] exp_data);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    in_word   = word;
    in_shamt  = sh;
    in_data   = d;
    in_tag    = tag;
    cycle();
    in_valid  = 1'b0;
    n_checks++;
    if (!last_fire_in) begin
      n_fail++;
      $display("FAIL %s_accept: got in_ready=0, required 1", name);
    end
    for (int i = 1; i < PIPE; i++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_early: got out_valid=%b at %0d cycles, required 0", name, out_valid, i);
      end
      cycle();
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== exp_data || out_tag !== tag) begin
      n_fail++;
      $display("FAIL %s: got valid=%b data=%h tag=%h, required valid=1 data=%h tag=%h",
               name, out_valid, out_data, out_tag, exp_data, tag);
    end
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b data=%h tag=%h, required all 0",
               out_valid, out_data, out_tag);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_shift_rotate();
    run_one("sra63",  3'd2, 1'b0, 6'd63, 64'h8000_0000_0000_0000, 5'h1A, 64'hFFFF_FFFF_FFFF_FFFF);
    run_one("ror1",   3'd4, 1'b0, 6'd1,  64'h1,                   5'h03, 64'h8000_0000_0000_0000);
    run_one("rol4",   3'd3, 1'b0, 6'd4,  64'h8000_0000_0000_0001, 5'h04, 64'h18);
    run_one("sll0",   3'd0, 1'b0, 6'd0,  64'h1,                   5'h05, 64'h1);
    run_one("srl63",  3'd1, 1'b0, 6'd63, 64'hF000_0000_0000_0000, 5'h06, 64'h1);
    run_one("rsvd",   3'd6, 1'b0, 6'd3,  64'hDEAD_BEEF_0123_4567, 5'h07, 64'h0);
  endtask

  task automatic test_word();
    run_one("srlw31", 3'd1, 1'b1, 6'd31, 64'hFFFF_FFFF_8000_0000, 5'h08, 64'h1);
    run_one("sraw31", 3'd2, 1'b1, 6'd31, 64'hFFFF_FFFF_8000_0000, 5'h09, 64'hFFFF_FFFF_FFFF_FFFF);
    run_one("sllw31", 3'd0, 1'b1, 6'd31, 64'h1,                   5'h0A, 64'hFFFF_FFFF_8000_0000);
    run_one("rolw1",  3'd3, 1'b1, 6'd1,  64'h8000_0001,           5'h0B, 64'h3);
    run_one("srlw_mask", 3'd1, 1'b1, 6'd33, 64'h0000_0000_0000_0004, 5'h0C, 64'h2);
  endtask

  task automatic test_backpressure();
    int accepted;
    sb_on    = 1'b1;
    n_out    = 0;
    accepted = 0;
    for (int c = 0; c < 60 && (accepted < 6 || exp_q.size() > 0); c++) begin
      out_ready = (c >= 5);
      in_valid  = (accepted < 6);
      in_op     = 3'(accepted % 5);
      in_word   = 1'b0;
      in_shamt  = 6'($urandom_range(0, 63));
      in_data   = {$urandom, $urandom};
      in_tag    = 5'(accepted + 16);
      #1;
      if (c == 2) begin
        n_checks++;
        if (in_ready !== 1'b0 || accepted != 2) begin
          n_fail++;
          $display("FAIL bp_full: got in_ready=%b accepted=%0d, required 0 and 2", in_ready, accepted);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_passthrough_ready: got %b, required 1", in_ready);
        end
      end
      cycle();
      if (last_fire_in) accepted++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (accepted != 6 || n_out != 6 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count: got accepted=%0d emitted=%0d left=%0d, required 6 6 0",
               accepted, n_out, exp_q.size());
    end
    sb_on = 1'b0;
  endtask

  task automatic test_back_to_back();
    int misses;
    sb_on     = 1'b1;
    n_out     = 0;
    misses    = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_op    = 3'($urandom_range(0, 4));
      in_word  = 1'($urandom_range(0, 1));
      in_shamt = 6'($urandom_range(0, 63));
      in_data  = {$urandom, $urandom};
      in_tag   = 5'(i);
      cycle();
      if (!last_fire_in) misses++;
    end
    n_checks++;
    if (misses != 0) begin
      n_fail++;
      $display("FAIL b2b_throughput: got %0d stalled cycles, required 0", misses);
    end
    drain(PIPE + 2);
    n_checks++;
    if (n_out != 10) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, required 10", n_out);
    end
    sb_on = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_op    = 3'd0;
      in_word  = 1'b0;
      in_shamt = 6'(i + 1);
      in_data  = 64'h1;
      in_tag   = 5'(i + 20);
      cycle();
    end
    flush    = 1'b1;
    in_tag   = 5'h1E;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_in_ready: got %b, required 0", in_ready);
    end
    cycle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_out_valid: got %b tag=%h %0d cycles after flush, required 0",
                 out_valid, out_tag, i);
      end
      cycle();
    end
    run_one("after_flush", 3'd1, 1'b0, 6'd4, 64'h100, 5'h11, 64'h10);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_op    = 3'd0;
      in_word  = 1'b0;
      in_shamt = 6'd0;
      in_data  = 64'h1;
      in_tag   = 5'h1F;
      cycle();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got valid=%b data=%h tag=%h, required all 0",
               out_valid, out_data, out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b, required 1", in_ready);
    end
    @(negedge clk);
    run_one("after_reset", 3'd4, 1'b0, 6'd8, 64'hAB, 5'h15, 64'hAB00_0000_0000_0000);
  endtask

  task automatic test_soak();
    sb_on = 1'b1;
    n_out = 0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      in_op     = 3'($urandom_range(0, 7));
      in_word   = 1'($urandom_range(0, 1));
      in_shamt  = 6'($urandom_range(0, 63));
      in_data   = ($urandom_range(0, 3) == 0) ? {32'hFFFF_FFFF, $urandom} : {$urandom, $urandom};
      in_tag    = 5'($urandom);
      cycle();
    end
    flush = 1'b0;
    drain(40);
    n_checks++;
    if (n_out < 100) begin
      n_fail++;
      $display("FAIL soak_activity: got %0d results, required at least 100", n_out);
    end
    sb_on = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_shift_rotate();
    test_word();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
